// File: rtl/timer_arbiter.sv
// timer_arbiter: two-requester round-robin run timer with shared counter and inter-run gap.
// Revision 1.0
`default_nettype none

module timer_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] qout,
  output logic             busy,
  output logic [1:0]       done,
  output logic             abort
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [1:0]       done_q, done_d;
  logic             abort_q, abort_d;
  logic             last_q, last_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             pick;
  logic             run_last;
  logic             cur;

  // A latched length of zero wraps to all-ones here, giving a full 2^WIDTH run.
  assign run_last = (qout_q == (len_q - WIDTH'(1)));
  assign cur      = gnt_q[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    qout_d  = qout_q;
    len_d   = len_q;
    done_d  = 2'b00;
    abort_d = 1'b0;
    last_d  = last_q;
    gap_d   = gap_q;
    pick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          pick    = (req == 2'b11) ? ~last_q : req[1];
          state_d = S_RUN;
          gnt_d   = pick ? 2'b10 : 2'b01;
          qout_d  = '0;
          len_d   = pick ? len1 : len0;
          last_d  = pick;
        end
      end
      S_RUN: begin
        if (run_last || !req[cur]) begin
          if (run_last) done_d = gnt_q;
          else          abort_d = 1'b1;
          gnt_d  = 2'b00;
          qout_d = '0;
          if (GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GW'(GAP - 1);
          end
        end else begin
          qout_d = qout_q + WIDTH'(1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_q resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      qout_q  <= '0;
      len_q   <= '0;
      done_q  <= 2'b00;
      abort_q <= 1'b0;
      last_q  <= 1'b1;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      qout_q  <= qout_d;
      len_q   <= len_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  assign gnt   = gnt_q;
  assign qout  = qout_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign abort = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed stimulus with a cycle-level reference model and literal checkpoints.
// Revision 1.0
`default_nettype none

module tb_timer_arbiter;

  localparam int WIDTH = 8;
  localparam int GAP   = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [WIDTH-1:0] len0 = '0;
  logic [WIDTH-1:0] len1 = '0;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] qout;
  logic             busy;
  logic [1:0]       done;
  logic             abort;

  int n_tests = 0;
  int n_fail  = 0;

  timer_arbiter #(.WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .qout(qout), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), count within run, run length as a plain integer.
  int         m_mode;   // 0 idle, 1 running, 2 gap
  int         m_owner;
  int         m_q;
  int         m_len;
  int         m_gap;
  int         m_last;
  logic [1:0] m_done;
  logic       m_abort;

  task automatic finish_run();
    m_owner = -1;
    m_q     = 0;
    m_gap   = GAP;
    m_mode  = (GAP == 0) ? 0 : 2;
  endtask

  task automatic model_step();
    m_done  = 2'b00;
    m_abort = 1'b0;
    if (reset) begin
      m_mode = 0; m_owner = -1; m_q = 0; m_last = 1; m_gap = 0;
    end else begin
      case (m_mode)
        0: if (req != 2'b00) begin
          if (req == 2'b11) m_owner = 1 - m_last;
          else              m_owner = req[1] ? 1 : 0;
          m_last = m_owner;
          m_q    = 0;
          m_len  = (m_owner == 1) ? int'(len1) : int'(len0);
          if (m_len == 0) m_len = 1 << WIDTH;
          m_mode = 1;
        end
        1: begin
          if (m_q == m_len - 1) begin
            m_done[m_owner] = 1'b1;
            finish_run();
          end else if (!req[m_owner]) begin
            m_abort = 1'b1;
            finish_run();
          end else begin
            m_q++;
          end
        end
        default: begin
          m_gap--;
          if (m_gap == 0) m_mode = 0;
        end
      endcase
    end
  endtask

  always @(posedge clk or posedge reset) model_step();

  always @(negedge clk) begin
    chk("cmp_gnt", gnt, (m_owner < 0) ? 32'd0 : (m_owner == 0 ? 32'd1 : 32'd2));
    chk("cmp_qout", qout, m_q);
    chk("cmp_busy", busy, (m_mode != 0));
    chk("cmp_done", done, m_done);
    chk("cmp_abort", abort, m_abort);
    chk("inv_onehot", ($countones(gnt) <= 1), 1);
    chk("inv_done_abort", (done != 0) && abort, 0);
    chk("inv_qout_idle", (gnt == 0) && (qout != 0), 0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset held three cycles, then a single length-5 run.
    reset = 1'b1;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_qout", qout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    reset = 1'b0;
    req   = 2'b01;
    len0  = 8'd5;
    step();
    chk("r1_gnt", gnt, 2'b01);
    chk("r1_q0", qout, 0);
    chk("r1_busy", busy, 1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("r1_qcount", qout, k);
    end
    step();
    chk("r1_done", done, 2'b01);
    chk("r1_done_q", qout, 0);
    chk("r1_done_gnt", gnt, 0);
    chk("r1_gap_busy", busy, 1);
    req = 2'b00;
    step();
    chk("r1_idle_busy", busy, 0);
    step();

    // Continuous contention alternates grants with two idle cycles between runs.
    do_reset();
    req  = 2'b11;
    len0 = 8'd2;
    len1 = 8'd2;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] e;
      step();
      if ((i % 4) < 2) e = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
      else             e = 2'b00;
      chk("rr_gnt", gnt, e);
    end
    req = 2'b00;
    step();
    step();

    // Length zero on requester 1 runs the full counter range.
    req  = 2'b10;
    len1 = 8'd0;
    step();
    chk("full_gnt", gnt, 2'b10);
    for (int k = 0; k < 256; k++) begin
      chk("full_q", qout, k);
      step();
    end
    chk("full_done", done, 2'b10);
    req = 2'b00;
    step();
    step();

    // Withdrawal mid-run aborts; withdrawal on the final count completes.
    req  = 2'b01;
    len0 = 8'd10;
    repeat (4) step();
    chk("ab_q3", qout, 3);
    req = 2'b00;
    step();
    chk("ab_gnt", gnt, 0);
    chk("ab_q", qout, 0);
    chk("ab_abort", abort, 1);
    chk("ab_done", done, 0);
    step();
    req = 2'b01;
    step();
    chk("ab2_gnt", gnt, 2'b01);
    for (int k = 1; k < 10; k++) step();
    chk("ab2_q9", qout, 9);
    req = 2'b00;
    step();
    chk("ab2_done", done, 2'b01);
    chk("ab2_abort", abort, 0);
    step();
    step();

    // Asynchronous reset mid-run, then contention favours requester 0.
    req  = 2'b01;
    len0 = 8'd10;
    repeat (7) step();
    chk("ar_q6", qout, 6);
    #2 reset = 1'b1;
    #1;
    chk("ar_gnt", gnt, 0);
    chk("ar_qout", qout, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_abort", abort, 0);
    step();
    chk("ar_done2", done, 0);
    chk("ar_abort2", abort, 0);
    reset = 1'b0;
    req   = 2'b11;
    step();
    chk("ar_first", gnt, 2'b01);
    req = 2'b00;
    repeat (3) step();

    // Length change after grant does not affect the active run.
    do_reset();
    req  = 2'b01;
    len0 = 8'd4;
    step();
    chk("ln_gnt", gnt, 2'b01);
    len0 = 8'd9;
    repeat (3) step();
    chk("ln_q3", qout, 3);
    step();
    chk("ln_done", done, 2'b01);
    chk("ln_q", qout, 0);
    req = 2'b00;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, counter and run-length width in bits.
REQ-002 Parameter: GAP, default 1, idle cycles inserted between consecutive runs (0 allowed).
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  2  per-requester run request, level, bit i = requester i.
REQ-006 Port: len0  input  WIDTH  run length for requester 0, sampled at grant.
REQ-007 Port: len1  input  WIDTH  run length for requester 1, sampled at grant.
REQ-008 Port: gnt  output  2  one-hot grant, high for the whole run.
REQ-009 Port: qout  output  WIDTH  shared counter value.
REQ-010 Port: busy  output  1  high in RUN or GAP.
REQ-011 Port: done  output  2  one-cycle completion pulse, bit i = requester i.
REQ-012 Port: abort  output  1  one-cycle pulse when a run ends by request withdrawal.

Function
REQ-013 States SHALL be IDLE, RUN and GAP, one-hot or encoded.
REQ-014 IDLE with req != 0 at an edge -> next cycle: RUN, gnt set to the chosen requester, qout = 0, run length latched from that requester's len input.
REQ-015 Arbitration SHALL be round-robin: if only one bit of req is set, grant it; if both are set, grant the requester not granted most recently.
REQ-016 The round-robin pointer SHALL update only on grant, not on done or abort.
REQ-017 In RUN, qout SHALL increment by 1 each cycle, modulo 2^WIDTH.
REQ-018 A run SHALL last exactly L cycles, with qout = 0..L-1, where L is the latched length; latched length 0 means L = 2^WIDTH.
REQ-019 In the cycle after the final count (qout = L-1), gnt SHALL be 0, qout SHALL be 0, done[i] SHALL pulse for one cycle, and the state SHALL go to GAP (or to IDLE when GAP = 0).
REQ-020 If req[granted] is low at an edge during RUN -> next cycle: gnt = 0, qout = 0, abort pulses, no done, state GAP (or IDLE when GAP = 0).
REQ-021 Completion SHALL take priority if withdrawal coincides with the final count: done pulses, abort does not.
REQ-022 GAP SHALL last exactly GAP cycles with gnt = 0 and qout = 0, then go to IDLE; requests are not granted during GAP.
REQ-023 len0 and len1 changes after grant SHALL NOT affect the active run.
REQ-024 Grant latency SHALL be 1 cycle from the first IDLE edge with req asserted; back-to-back runs SHALL be separated by GAP + 1 cycles of gnt low (done cycle + GAP).
REQ-025 gnt SHALL never have more than one bit set; done and abort SHALL never be high together.
REQ-026 qout SHALL be 0 whenever gnt = 0.

Reset
REQ-027 While reset is high, outputs SHALL be forced immediately, independent of clk: gnt = 0, qout = 0, busy = 0, done = 0, abort = 0.
REQ-028 While reset is high, state SHALL be IDLE and the round-robin pointer SHALL favour requester 0 on the first contention.
REQ-029 Reset asserted mid-run SHALL cancel the run without a done or abort pulse.
REQ-030 After reset falls, the first grant SHALL follow REQ-014 at the next qualifying edge.

Verification
REQ-031 Reset held 3 cycles, then req = 01, len0 = 5 -> gnt = 01 one cycle later; qout 0,1,2,3,4; then done = 01 with qout = 0; busy high through GAP.
REQ-032 req = 11 continuously, len0 = len1 = 2, GAP = 1 -> grants alternate 01, 10, 01, ...; each pair of runs separated by 2 cycles with gnt = 0.
REQ-033 req = 10, len1 = 0 -> 256 RUN cycles, qout 0..255, then done = 10.
REQ-034 req = 01, len0 = 10; drop req[0] when qout = 3 -> next cycle: gnt = 0, qout = 0, abort = 1, done = 00; drop req[0] exactly when qout = 9 -> done = 01, abort = 0.
REQ-035 Assert reset asynchronously (between edges) when qout = 6 -> outputs zero immediately; no done or abort pulse; next req = 11 grants requester 0 first.
REQ-036 Change len0 from 4 to 9 one cycle after grant -> run still ends after 4 cycles.
